bus_arbiter: RTL and testbench

Round-robin RQ/GRANT arbiter that shares one memory bus (data or instruction) among `N_CORES` arbitration submodules. Each core's arbitration submodule raises its request line. The arbiter grants exactly one core at a time, holds the grant until that core drops its request, then waits for the memory's ready line to return low before arbitrating again. One instance sits in front of the shared data memory and a second instance in front of the shared instruction memory.

---
 rtl/bus_arb_pkg.sv | 17 +
 rtl/bus_arbiter_if.sv | 35 +++
 rtl/rr_priority_picker.sv | 31 +++
 rtl/bus_arbiter.sv | 126 ++++++++++++
 tb/tb_bus_arbiter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        GRANTED      = 2'b01,
        WAIT_MEM_LOW = 2'b10
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int owner_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the cores, the shared memory and the arbiter.
// master: requester/memory side; slave: arbiter side.
interface bus_arbiter_if #(
    parameter int N_CORES = 4
);
    import bus_arb_pkg::*;

    localparam int OWNER_W = owner_width(N_CORES);

    logic [N_CORES-1:0] Bus_RQ;
    logic               Bus_Mem_Ready;
    logic [N_CORES-1:0] Bus_GRANT;
    logic [OWNER_W-1:0] Bus_Owner;
    logic               Bus_Busy;
    logic               Arb_Timeout;

    modport master (
        output Bus_RQ,
        output Bus_Mem_Ready,
        input  Bus_GRANT,
        input  Bus_Owner,
        input  Bus_Busy,
        input  Arb_Timeout
    );

    modport slave (
        input  Bus_RQ,
        input  Bus_Mem_Ready,
        output Bus_GRANT,
        output Bus_Owner,
        output Bus_Busy,
        output Arb_Timeout
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward and wrapping from N_CORES-1 back to 0.
module rr_priority_picker
    import bus_arb_pkg::*;
#(
    parameter  int N_CORES = 4,
    localparam int OWNER_W = owner_width(N_CORES)
) (
    input  logic [N_CORES-1:0] req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [OWNER_W-1:0] winner,
    output logic               valid
);

    logic [OWNER_W-1:0] idx;

    // Scan requesters in rotated order and keep the first hit.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            idx = OWNER_W'((32'(ptr) + i) % 32'(N_CORES));
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin RQ/GRANT arbiter for one shared memory bus.
// Optional grant-hold timeout compiled in with BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_CORES        = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);

    localparam int                 OWNER_W  = owner_width(N_CORES);
    localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(N_CORES - 1);

    if (N_CORES < 2 || N_CORES > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("bus_arbiter: N_CORES must be 2..16 and TIMEOUT_CYCLES at least 2");
    end

    arb_state_t         state;
    logic [N_CORES-1:0] grant;
    logic [OWNER_W-1:0] owner;
    logic [OWNER_W-1:0] rr_ptr;
    logic               busy;
    logic [N_CORES-1:0] eligible;
    logic [OWNER_W-1:0] pick_idx;
    logic               pick_valid;
    logic               owner_rq;

    assign owner_rq = bus.Bus_RQ[owner];

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int                HOLD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT_CYCLES - 1);

    logic [HOLD_W-1:0]  hold_cnt;
    logic [N_CORES-1:0] mask;
    logic               timeout_pulse;
    logic               hold_expired;

    assign hold_expired    = (hold_cnt == HOLD_LAST);
    // A core that lost its grant by timeout sits out until it drops RQ once.
    assign eligible        = bus.Bus_RQ & ~mask;
    assign bus.Arb_Timeout = timeout_pulse;
`else
    assign eligible        = bus.Bus_RQ;
    assign bus.Arb_Timeout = 1'b0;
`endif

    rr_priority_picker #(
        .N_CORES (N_CORES)
    ) u_picker (
        .req    (eligible),
        .ptr    (rr_ptr),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    // Arbitration FSM with registered grant/owner/busy outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            owner  <= '0;
            busy   <= 1'b0;
            rr_ptr <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt      <= '0;
            mask          <= '0;
            timeout_pulse <= 1'b0;
`endif
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            timeout_pulse <= 1'b0;
            mask          <= mask & bus.Bus_RQ;
`endif
            unique case (state)
                IDLE: begin
                    if (pick_valid && !bus.Bus_Mem_Ready) begin
                        state  <= GRANTED;
                        grant  <= N_CORES'(1) << pick_idx;
                        owner  <= pick_idx;
                        busy   <= 1'b1;
                        rr_ptr <= (pick_idx == LAST_IDX) ? '0 : pick_idx + OWNER_W'(1);
`ifdef BUS_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                GRANTED: begin
                    if (!owner_rq) begin
                        state <= WAIT_MEM_LOW;
                        grant <= '0;
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    else if (hold_expired) begin
                        state         <= WAIT_MEM_LOW;
                        grant         <= '0;
                        timeout_pulse <= 1'b1;
                        mask          <= (mask & bus.Bus_RQ) | (N_CORES'(1) << owner);
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
`endif
                end
                WAIT_MEM_LOW: begin
                    if (!bus.Bus_Mem_Ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Bus_GRANT = grant;
    assign bus.Bus_Owner = owner;
    assign bus.Bus_Busy  = busy;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (N_CORES=4, TIMEOUT_CYCLES=8).
// Timeout steps are compiled when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    // 10-unit clock.
    always #5 clk = ~clk;

    bus_arbiter_if #(.N_CORES(4)) bif ();

    bus_arbiter #(
        .N_CORES        (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                             input logic b, input logic t);
        check({tag, ".grant"},   32'(bif.Bus_GRANT),   32'(g));
        check({tag, ".owner"},   32'(bif.Bus_Owner),   32'(o));
        check({tag, ".busy"},    32'(bif.Bus_Busy),    32'(b));
        check({tag, ".timeout"}, 32'(bif.Arb_Timeout), 32'(t));
    endtask

    int         order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    logic [1:0] exp_o;

    initial begin
        reset             = 1'b1;
        bif.Bus_RQ        = 4'b0000;
        bif.Bus_Mem_Ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single request from core 2.
        bif.Bus_RQ = 4'b0100;
        step();
        check_all("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        bif.Bus_RQ = 4'b0000;
        step();
        check_all("single_release", 4'b0000, 2'd2, 1'b1, 1'b0);
        step();
        check_all("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Round robin from a fresh pointer.
        reset = 1'b1;
        step();
        reset = 1'b0;
        bif.Bus_RQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << order[i];
            exp_o = 2'(order[i]);
            step();
            check_all($sformatf("rr%0d_grant", i), exp_g, exp_o, 1'b1, 1'b0);
            step();
            step();
            check_all($sformatf("rr%0d_hold", i), exp_g, exp_o, 1'b1, 1'b0);
            bif.Bus_RQ[order[i]] = 1'b0;
            step();
            check_all($sformatf("rr%0d_wait", i), 4'b0000, exp_o, 1'b1, 1'b0);
            bif.Bus_RQ = 4'b1111;
            step();
            check_all($sformatf("rr%0d_idle", i), 4'b0000, exp_o, 1'b0, 1'b0);
        end
        bif.Bus_RQ = 4'b0000;
        step();

        // Memory ready held high stretches WAIT_MEM_LOW and blocks IDLE.
        bif.Bus_RQ = 4'b0010;
        step();
        check_all("mem_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
        bif.Bus_Mem_Ready = 1'b1;
        bif.Bus_RQ        = 4'b0000;
        step();
        check_all("mem_wait0", 4'b0000, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_all($sformatf("mem_wait%0d", i + 1), 4'b0000, 2'd1, 1'b1, 1'b0);
        end
        bif.Bus_Mem_Ready = 1'b0;
        step();
        check_all("mem_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
        bif.Bus_Mem_Ready = 1'b1;
        bif.Bus_RQ        = 4'b0100;
        step();
        check_all("mem_blocked", 4'b0000, 2'd1, 1'b0, 1'b0);
        bif.Bus_Mem_Ready = 1'b0;
        step();
        check_all("mem_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Reset in the middle of a grant to core 1.
        bif.Bus_RQ = 4'b0000;
        step();
        step();
        bif.Bus_RQ = 4'b0010;
        step();
        check_all("pre_reset_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        reset             = 1'b1;
        bif.Bus_RQ        = 4'b1111;
        bif.Bus_Mem_Ready = 1'b1;
        step();
        check_all("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset             = 1'b0;
        bif.Bus_Mem_Ready = 1'b0;
        step();
        check_all("post_reset_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        bif.Bus_RQ = 4'b0000;
        step();
        step();

`ifdef BUS_ARB_TIMEOUT_EN
        // Core 3 hogs the bus and is revoked after 8 granted cycles.
        bif.Bus_RQ = 4'b1000;
        step();
        check_all("to_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
        bif.Bus_RQ = 4'b1001;
        for (int i = 0; i < 7; i++) begin
            step();
            check_all($sformatf("to_hold%0d", i + 1), 4'b1000, 2'd3, 1'b1, 1'b0);
        end
        step();
        check_all("to_revoke", 4'b0000, 2'd3, 1'b1, 1'b1);
        step();
        check_all("to_idle", 4'b0000, 2'd3, 1'b0, 1'b0);
        step();
        check_all("to_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
        bif.Bus_RQ = 4'b1000;
        step();
        step();
        step();
        check_all("to_masked", 4'b0000, 2'd0, 1'b0, 1'b0);
        bif.Bus_RQ = 4'b0000;
        step();
        bif.Bus_RQ = 4'b1000;
        step();
        check_all("to_regrant3", 4'b1000, 2'd3, 1'b1, 1'b0);
`else
        // Without the timeout a grant is held indefinitely.
        bif.Bus_RQ = 4'b1000;
        step();
        check_all("hold_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
        bif.Bus_RQ = 4'b1001;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("hold_to%0d", i), 32'(bif.Arb_Timeout), 32'd0);
        end
        check_all("hold_still3", 4'b1000, 2'd3, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
